dblbuf_swap_ctrl: RTL and testbench

Controller for the two frame BRAMs (buffer0/buffer1) that sit between the graphics pipeline and the VGA scanout.
- Routes graphics pixel writes to the back buffer and VGA reads to the front buffer.
- Swaps the buffers only when graphics has finished a frame and VGA has reached a frame boundary, so no tearing occurs.
- Stalls graphics while a finished frame waits for the swap, and reports swap and repeated-frame statistics.
- Sits in the vga_clock domain, between the BRAM wrapper, the graphics core and vga_top.

---
 rtl/dblbuf_swap_ctrl.sv | 146 ++++++++++++++
 tb/tb_dblbuf_swap_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dblbuf_swap_ctrl.sv
// dblbuf_swap_ctrl: double-buffer controller between the graphics core and VGA scanout.
//
// Graphics writes go to the back buffer (index !front_sel) and VGA reads come from the
// front buffer. The buffers swap only once graphics has finished a frame and VGA has hit
// a frame boundary, so scanout never shows a half-drawn frame.
//
// Ports:
//   clk, rst_b                     clock, synchronous active-low reset
//   gfx_addr/color/wen             graphics pixel write
//   gfx_frame_done                 pulse: graphics finished the current back frame
//   gfx_stall                      high while writes are not accepted
//   vga_addr, vga_frame_end        scanout read address, frame boundary pulse
//   vga_color                      front-buffer pixel, one cycle after vga_addr
//   buffer{0,1}_{addr,din,en,we}   BRAM controls
//   buffer{0,1}_dout               BRAM read data (1-cycle latency)
//   front_sel                      0: buffer0 is front, 1: buffer1 is front
//   swap_count, repeat_count       saturating statistics

module dblbuf_swap_ctrl #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 15,
    parameter int unsigned FRAME_PIXELS = 38400
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [ADDR_W-1:0] gfx_addr,
    input  logic [DATA_W-1:0] gfx_color,
    input  logic              gfx_wen,
    input  logic              gfx_frame_done,
    output logic              gfx_stall,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_frame_end,
    output logic [DATA_W-1:0] vga_color,
    output logic [ADDR_W-1:0] buffer0_addr,
    output logic [ADDR_W-1:0] buffer1_addr,
    output logic [DATA_W-1:0] buffer0_din,
    output logic [DATA_W-1:0] buffer1_din,
    input  logic [DATA_W-1:0] buffer0_dout,
    input  logic [DATA_W-1:0] buffer1_dout,
    output logic              buffer0_en,
    output logic              buffer1_en,
    output logic              buffer0_we,
    output logic              buffer1_we,
    output logic              front_sel,
    output logic [15:0]       swap_count,
    output logic [15:0]       repeat_count
);

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StReady = 2'd1,
        StSwap  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic        rd_sel_q;
    logic [15:0] swap_count_q, swap_count_d;
    logic [15:0] repeat_count_q, repeat_count_d;
    logic        wr_ok;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q        <= StFill;
            front_sel_q    <= 1'b0;
            rd_sel_q       <= 1'b0;
            swap_count_q   <= 16'h0000;
            repeat_count_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            front_sel_q    <= front_sel_d;
            // Lags front_sel by one cycle to match the BRAM read latency.
            rd_sel_q       <= front_sel_q;
            swap_count_q   <= swap_count_d;
            repeat_count_q <= repeat_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        front_sel_d    = front_sel_q;
        swap_count_d   = swap_count_q;
        repeat_count_d = repeat_count_q;
        unique case (state_q)
            StFill: begin
                if (gfx_frame_done && vga_frame_end) begin
                    state_d = StSwap;
                end else if (gfx_frame_done) begin
                    state_d = StReady;
                end else if (vga_frame_end) begin
                    // VGA starts another frame with nothing new: stale frame shown again.
                    if (repeat_count_q != 16'hFFFF) begin
                        repeat_count_d = repeat_count_q + 16'd1;
                    end
                end
            end
            StReady: begin
                if (vga_frame_end) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                state_d     = StFill;
                front_sel_d = ~front_sel_q;
                if (swap_count_q != 16'hFFFF) begin
                    swap_count_d = swap_count_q + 16'd1;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    assign gfx_stall = (state_q != StFill) || !rst_b;
    assign wr_ok     = gfx_wen && !gfx_stall && (gfx_addr < ADDR_W'(FRAME_PIXELS)) && rst_b;

    // Front buffer is read-only; back buffer is write-only, so no BRAM sees both at once.
    always_comb begin
        if (front_sel_q) begin
            buffer1_addr = vga_addr;
            buffer1_din  = '0;
            buffer1_en   = rst_b;
            buffer1_we   = 1'b0;
            buffer0_addr = gfx_addr;
            buffer0_din  = gfx_color;
            buffer0_en   = wr_ok;
            buffer0_we   = wr_ok;
        end else begin
            buffer0_addr = vga_addr;
            buffer0_din  = '0;
            buffer0_en   = rst_b;
            buffer0_we   = 1'b0;
            buffer1_addr = gfx_addr;
            buffer1_din  = gfx_color;
            buffer1_en   = wr_ok;
            buffer1_we   = wr_ok;
        end
    end

    assign vga_color    = rd_sel_q ? buffer1_dout : buffer0_dout;
    assign front_sel    = front_sel_q;
    assign swap_count   = swap_count_q;
    assign repeat_count = repeat_count_q;

endmodule

// File: tb/tb_dblbuf_swap_ctrl.sv
// Directed bench for dblbuf_swap_ctrl with two behavioural 1-cycle-latency BRAMs.
module tb_dblbuf_swap_ctrl;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 15;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [ADDR_W-1:0] gfx_addr;
    logic [DATA_W-1:0] gfx_color;
    logic              gfx_wen;
    logic              gfx_frame_done;
    logic              gfx_stall;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_frame_end;
    logic [DATA_W-1:0] vga_color;
    logic [ADDR_W-1:0] buffer0_addr, buffer1_addr;
    logic [DATA_W-1:0] buffer0_din, buffer1_din;
    logic [DATA_W-1:0] buffer0_dout, buffer1_dout;
    logic              buffer0_en, buffer1_en, buffer0_we, buffer1_we;
    logic              front_sel;
    logic [15:0]       swap_count, repeat_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (buffer0_en) begin
            if (buffer0_we) mem0[buffer0_addr] <= buffer0_din;
            buffer0_dout <= mem0[buffer0_addr];
        end
        if (buffer1_en) begin
            if (buffer1_we) mem1[buffer1_addr] <= buffer1_din;
            buffer1_dout <= mem1[buffer1_addr];
        end
    end

    dblbuf_swap_ctrl dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .gfx_addr       (gfx_addr),
        .gfx_color      (gfx_color),
        .gfx_wen        (gfx_wen),
        .gfx_frame_done (gfx_frame_done),
        .gfx_stall      (gfx_stall),
        .vga_addr       (vga_addr),
        .vga_frame_end  (vga_frame_end),
        .vga_color      (vga_color),
        .buffer0_addr   (buffer0_addr),
        .buffer1_addr   (buffer1_addr),
        .buffer0_din    (buffer0_din),
        .buffer1_din    (buffer1_din),
        .buffer0_dout   (buffer0_dout),
        .buffer1_dout   (buffer1_dout),
        .buffer0_en     (buffer0_en),
        .buffer1_en     (buffer1_en),
        .buffer0_we     (buffer0_we),
        .buffer1_we     (buffer1_we),
        .front_sel      (front_sel),
        .swap_count     (swap_count),
        .repeat_count   (repeat_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        gfx_wen        = 1'b0;
        gfx_frame_done = 1'b0;
        vga_frame_end  = 1'b0;
    endtask

    initial begin
        rst_b          = 1'b0;
        gfx_addr       = 17'd5;
        gfx_color      = 15'h7C00;
        gfx_wen        = 1'b1;
        gfx_frame_done = 1'b0;
        vga_addr       = '0;
        vga_frame_end  = 1'b0;

        // Reset held 3 cycles with a write request pending.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_we0", buffer0_we, 0);
            check("rst_we1", buffer1_we, 0);
            check("rst_stall", gfx_stall, 1);
        end
        check("rst_front", front_sel, 0);
        check("rst_swap", swap_count, 0);
        check("rst_repeat", repeat_count, 0);

        // Basic swap: write addr 5 into back buffer1.
        rst_b = 1'b1;
        #1;
        check("wr_stall", gfx_stall, 0);
        check("wr_we1", buffer1_we, 1);
        check("wr_we0", buffer0_we, 0);
        step();
        gfx_wen        = 1'b0;
        gfx_frame_done = 1'b1;
        step();
        gfx_frame_done = 1'b0;
        #1;
        check("ready_stall", gfx_stall, 1);
        for (int i = 0; i < 9; i++) step();
        check("ready_hold_stall", gfx_stall, 1);
        check("ready_front", front_sel, 0);
        vga_frame_end = 1'b1;
        step();
        vga_frame_end = 1'b0;
        #1;
        check("swap_stall", gfx_stall, 1);
        check("swap_front_old", front_sel, 0);
        step();
        check("post_swap_front", front_sel, 1);
        check("post_swap_count", swap_count, 1);
        check("post_swap_stall", gfx_stall, 0);
        check("post_swap_repeat", repeat_count, 0);
        vga_addr = 17'd5;
        step();
        check("vga_color", vga_color, 15'h7C00);

        // Simultaneous done and frame_end in FILL goes straight to SWAP.
        gfx_frame_done = 1'b1;
        vga_frame_end  = 1'b1;
        step();
        idle_inputs();
        #1;
        check("sim_swap_stall", gfx_stall, 1);
        check("sim_repeat", repeat_count, 0);
        step();
        check("sim_front", front_sel, 0);
        check("sim_swap_count", swap_count, 2);
        check("sim_stall", gfx_stall, 0);

        // Three stale frames.
        for (int i = 0; i < 3; i++) begin
            vga_frame_end = 1'b1;
            step();
            vga_frame_end = 1'b0;
            step();
        end
        check("stale_repeat", repeat_count, 3);
        check("stale_front", front_sel, 0);

        // Writes in READY are dropped.
        gfx_frame_done = 1'b1;
        step();
        gfx_frame_done = 1'b0;
        gfx_wen        = 1'b1;
        gfx_addr       = 17'd7;
        #1;
        check("ready_drop_we1", buffer1_we, 0);
        check("ready_drop_we0", buffer0_we, 0);
        gfx_wen       = 1'b0;
        vga_frame_end = 1'b1;
        step();
        vga_frame_end = 1'b0;
        step();
        check("bnd_front", front_sel, 1);
        check("bnd_swap_count", swap_count, 3);

        // Address bounds; back buffer is now buffer0.
        gfx_wen  = 1'b1;
        gfx_addr = 17'd38400;
        #1;
        check("oob_we0", buffer0_we, 0);
        check("oob_we1", buffer1_we, 0);
        gfx_addr = 17'd38399;
        #1;
        check("last_we0", buffer0_we, 1);
        check("last_we1", buffer1_we, 0);
        check("front_en1", buffer1_en, 1);
        gfx_wen = 1'b0;
        step();

        // Saturation: 65531 back-to-back stale frames take repeat_count from 3 to FFFE.
        vga_frame_end = 1'b1;
        for (int i = 0; i < 65531; i++) @(posedge clk);
        #1;
        vga_frame_end = 1'b0;
        check("sat_pre", repeat_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            vga_frame_end = 1'b1;
            step();
            vga_frame_end = 1'b0;
            step();
        end
        check("sat_hold", repeat_count, 16'hFFFF);
        check("sat_front", front_sel, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
